// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared constants for the ALU command controller: unit selects, opcode
// field positions and FSM state encoding.
package alu_cmd_ctrl_pkg;

   localparam logic [1:0] UNIT_ARITH = 2'd0;
   localparam logic [1:0] UNIT_LOGIC = 2'd1;
   localparam logic [1:0] UNIT_CMP   = 2'd2;
   localparam logic [1:0] UNIT_SHIFT = 2'd3;

   localparam int OP_FUNC_LSB = 0;
   localparam int OP_UNIT_LSB = 4;
   localparam int OP_RSV_LSB  = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_A   = 3'd1,
      ST_GET_B   = 3'd2,
      ST_EXEC    = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_SEND    = 3'd5
   } state_t;

   // Bit order of the result is {shift, cmp, logic, arith}.
   function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
      logic [3:0] oh;
      case (unit)
         UNIT_ARITH: oh = 4'b0001;
         UNIT_LOGIC: oh = 4'b0010;
         UNIT_CMP:   oh = 4'b0100;
         UNIT_SHIFT: oh = 4'b1000;
         default:    oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/alu_cmd_ctrl_tx_byte_serializer.sv
// Parallel-load, LSB-first byte serializer with a valid/ready output and a
// combinational done strobe on the final handshake.
module tx_byte_serializer #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [width-1:0] din,
   input  logic             txReady,
   output logic [7:0]       txData,
   output logic             txValid,
   output logic             done
);

   localparam int NB = width / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   logic [width-1:0] sh_r;
   logic [width-1:0] sh_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [7:0]       tx_data_r;
   logic             tx_valid_r;
   logic             last_s;

   assign sh_nxt_s = sh_r >> 8;
   assign last_s   = (cnt_r == LAST);
   assign done     = tx_valid_r && txReady && last_s;
   assign txData   = tx_data_r;
   assign txValid  = tx_valid_r;

   // Load, hold while stalled, and step one byte per accepted handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_r       <= '0;
         cnt_r      <= '0;
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
      end else if (load) begin
         sh_r       <= din;
         cnt_r      <= '0;
         tx_data_r  <= din[7:0];
         tx_valid_r <= 1'b1;
      end else if (tx_valid_r && txReady) begin
         if (last_s) begin
            cnt_r      <= '0;
            tx_valid_r <= 1'b0;
         end else begin
            sh_r      <= sh_nxt_s;
            tx_data_r <= sh_nxt_s[7:0];
            cnt_r     <= cnt_r + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command frame decoder driving the ALU sub-units for one cycle
// and returning the captured result through a valid/ready byte stream.
module alu_cmd_ctrl
   import alu_cmd_ctrl_pkg::*;
#(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rxData,
   input  logic             rxValid,
   input  logic [width-1:0] aluResult,
   input  logic             aluValid,
   output logic [width-1:0] A,
   output logic [width-1:0] B,
   output logic [1:0]       aluFunc,
   output logic             arithEn,
   output logic             logicEn,
   output logic             cmpEn,
   output logic             shiftEn,
   output logic [7:0]       txData,
   output logic             txValid,
   input  logic             txReady,
   output logic             busy,
   output logic             errFlag
);

   localparam int NB = width / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic [1:0]       unit_r;
   logic [1:0]       func_sh_r;
   logic [width-1:0] a_sh_r;
   logic [width-1:0] b_sh_r;
   logic [width-1:0] a_r;
   logic [width-1:0] b_r;
   logic [1:0]       func_r;
   logic [3:0]       en_r;
   logic             busy_r;
   logic             err_r;
   logic             load_r;
   logic             tx_done_s;

   // New bytes enter at the top so the first (least significant) ends at bit 0.
   function automatic logic [width-1:0] shift_in(input logic [width-1:0] cur,
                                                 input logic [7:0] b);
      logic [width-1:0] t;
      t = cur >> 8;
      t[width-1 -: 8] = b;
      return t;
   endfunction

   assign A       = a_r;
   assign B       = b_r;
   assign aluFunc = func_r;
   assign arithEn = en_r[0];
   assign logicEn = en_r[1];
   assign cmpEn   = en_r[2];
   assign shiftEn = en_r[3];
   assign busy    = busy_r;
   assign errFlag = err_r;

   // Frame FSM; operands are published only on the edge entering EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         unit_r    <= 2'd0;
         func_sh_r <= 2'd0;
         a_sh_r    <= '0;
         b_sh_r    <= '0;
         a_r       <= '0;
         b_r       <= '0;
         func_r    <= 2'd0;
         en_r      <= 4'b0000;
         busy_r    <= 1'b0;
         err_r     <= 1'b0;
         load_r    <= 1'b0;
      end else begin
         en_r   <= 4'b0000;
         err_r  <= 1'b0;
         load_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (rxValid) begin
                  if (rxData[OP_RSV_LSB +: 2] == 2'b00) begin
                     unit_r    <= rxData[OP_UNIT_LSB +: 2];
                     func_sh_r <= rxData[OP_FUNC_LSB +: 2];
                     cnt_r     <= '0;
                     busy_r    <= 1'b1;
                     state_r   <= ST_GET_A;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            ST_GET_A: begin
               if (rxValid) begin
                  a_sh_r <= shift_in(a_sh_r, rxData);
                  if (cnt_r == LAST) begin
                     cnt_r   <= '0;
                     state_r <= ST_GET_B;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
            end
            ST_GET_B: begin
               if (rxValid) begin
                  b_sh_r <= shift_in(b_sh_r, rxData);
                  if (cnt_r == LAST) begin
                     cnt_r   <= '0;
                     a_r     <= a_sh_r;
                     b_r     <= shift_in(b_sh_r, rxData);
                     func_r  <= func_sh_r;
                     en_r    <= unit_onehot(unit_r);
                     state_r <= ST_EXEC;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
            end
            ST_EXEC: begin
               if (aluValid) begin
                  load_r  <= 1'b1;
                  state_r <= ST_CAPTURE;
               end else begin
                  err_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_CAPTURE: begin
               state_r <= ST_SEND;
            end
            ST_SEND: begin
               if (tx_done_s) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   tx_byte_serializer #(.width(width)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .load    (load_r),
      .din     (aluResult),
      .txReady (txReady),
      .txData  (txData),
      .txValid (txValid),
      .done    (tx_done_s)
   );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed self-checking bench for alu_cmd_ctrl (width = 16).
module tb_alu_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rxData;
   logic        rxValid;
   logic [15:0] aluResult;
   logic        aluValid;
   logic [15:0] A, B;
   logic [1:0]  aluFunc;
   logic        arithEn, logicEn, cmpEn, shiftEn;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic        busy;
   logic        errFlag;
   logic        ack_mode;

   int tests = 0;
   int fails = 0;
   int en_cnt [4];
   int err_cnt = 0;
   int txv_cnt = 0;
   logic [7:0] acc_q [$];
   int snap_err, snap_txv, snap_cmp, snap_en;

   always #5 clk = ~clk;

   assign aluValid = ack_mode & (arithEn | logicEn | cmpEn | shiftEn);

   alu_cmd_ctrl #(.width(16)) dut (
      .clk(clk), .rst(rst), .rxData(rxData), .rxValid(rxValid),
      .aluResult(aluResult), .aluValid(aluValid), .A(A), .B(B),
      .aluFunc(aluFunc), .arithEn(arithEn), .logicEn(logicEn),
      .cmpEn(cmpEn), .shiftEn(shiftEn), .txData(txData),
      .txValid(txValid), .txReady(txReady), .busy(busy), .errFlag(errFlag)
   );

   // Mid-cycle monitor: pulse counts and accepted tx bytes.
   always @(negedge clk) begin
      if (arithEn) en_cnt[0]++;
      if (logicEn) en_cnt[1]++;
      if (cmpEn)   en_cnt[2]++;
      if (shiftEn) en_cnt[3]++;
      if (errFlag) err_cnt++;
      if (txValid) txv_cnt++;
      if (txValid && txReady) acc_q.push_back(txData);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rxData  = b;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
      send_byte(op);
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(b[7:0]);
      send_byte(b[15:8]);
   endtask

   function automatic logic [31:0] acc_word();
      logic [31:0] w;
      w = 32'h0;
      foreach (acc_q[i]) w = (w << 8) | {24'h0, acc_q[i]};
      return w;
   endfunction

   function automatic int en_total();
      return en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      foreach (en_cnt[i]) en_cnt[i] = 0;
      rst = 1'b1; rxData = 8'h00; rxValid = 1'b0; aluResult = 16'h0000;
      txReady = 1'b1; ack_mode = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_A", {16'h0, A}, 32'h0);
      chk("rst_B", {16'h0, B}, 32'h0);
      chk("rst_outs", {24'h0, aluFunc, arithEn, logicEn, cmpEn, shiftEn, busy, errFlag}, 32'h0);
      chk("rst_tx", {23'h0, txValid, txData}, 32'h0);
      rst = 1'b0;
      tick();

      // compare, equal operands
      acc_q.delete();
      aluResult = 16'h0001;
      send_frame(8'h21, 16'h1234, 16'h1234);
      chk("cmp_en", {28'h0, shiftEn, cmpEn, logicEn, arithEn}, 32'h4);
      chk("cmp_A", {16'h0, A}, 32'h1234);
      chk("cmp_B", {16'h0, B}, 32'h1234);
      chk("cmp_func", {30'h0, aluFunc}, 32'h1);
      tick();
      chk("cmp_capture", {30'h0, cmpEn, txValid}, 32'h0);
      tick();
      chk("cmp_tx0", {23'h0, txValid, txData}, 32'h101);
      tick();
      chk("cmp_tx1", {23'h0, txValid, txData}, 32'h100);
      tick();
      chk("cmp_done", {30'h0, txValid, busy}, 32'h0);
      chk("cmp_bytes", acc_word(), 32'h0100);
      chk("cmp_nbytes", acc_q.size(), 32'd2);
      chk("cmp_pulses", en_cnt[2], 32'd1);

      // arithmetic with backpressure
      acc_q.delete();
      aluResult = 16'h0008;
      txReady = 1'b0;
      send_frame(8'h00, 16'h0005, 16'h0003);
      chk("add_en", {28'h0, shiftEn, cmpEn, logicEn, arithEn}, 32'h1);
      chk("add_AB", {A, B}, 32'h0005_0003);
      tick();
      tick();
      chk("add_tx0", {23'h0, txValid, txData}, 32'h108);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("add_hold0", {23'h0, txValid, txData}, 32'h108);
      end
      txReady = 1'b1;
      tick();
      txReady = 1'b0;
      chk("add_tx1", {23'h0, txValid, txData}, 32'h100);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("add_hold1", {23'h0, txValid, txData}, 32'h100);
      end
      txReady = 1'b1;
      tick();
      chk("add_done", {30'h0, txValid, busy}, 32'h0);
      chk("add_bytes", acc_word(), 32'h0800);
      chk("add_nbytes", acc_q.size(), 32'd2);

      // bad opcode
      snap_en = en_total();
      send_byte(8'hC1);
      chk("bad_err", {30'h0, errFlag, busy}, 32'h2);
      tick();
      chk("bad_err_end", {30'h0, errFlag, busy}, 32'h0);
      chk("bad_noen", en_total(), snap_en);

      // missing acknowledge
      ack_mode = 1'b0;
      snap_txv = txv_cnt;
      snap_cmp = en_cnt[2];
      send_frame(8'h22, 16'h5A5A, 16'h0101);
      chk("nak_en", {30'h0, cmpEn, errFlag}, 32'h2);
      tick();
      chk("nak_err", {29'h0, cmpEn, errFlag, busy}, 32'h2);
      tick();
      tick();
      chk("nak_err_end", {30'h0, errFlag, busy}, 32'h0);
      chk("nak_pulses", en_cnt[2] - snap_cmp, 32'd1);
      chk("nak_notx", txv_cnt - snap_txv, 32'd0);
      chk("nak_A", {16'h0, A}, 32'h5A5A);
      ack_mode = 1'b1;

      // reset after 3 of 5 bytes, then a fresh shift frame
      send_byte(8'h10);
      send_byte(8'hAA);
      send_byte(8'hBB);
      chk("mid_busy", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_AB", {A, B}, 32'h0);
      chk("mid_rst_outs", {22'h0, aluFunc, busy, errFlag, txValid, arithEn, logicEn, cmpEn, shiftEn}, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      acc_q.delete();
      aluResult = 16'h0F00;
      send_frame(8'h31, 16'h00F0, 16'h0004);
      chk("shf_en", {28'h0, shiftEn, cmpEn, logicEn, arithEn}, 32'h8);
      chk("shf_AB", {A, B}, 32'h00F0_0004);
      chk("shf_func", {30'h0, aluFunc}, 32'h1);
      tick();
      tick();
      chk("shf_tx0", {23'h0, txValid, txData}, 32'h100);
      tick();
      chk("shf_tx1", {23'h0, txValid, txData}, 32'h10F);
      tick();
      chk("shf_done", {31'h0, txValid}, 32'h0);
      chk("shf_bytes", acc_word(), 32'h000F);

      // stray rx during SEND, then a back-to-back frame
      acc_q.delete();
      aluResult = 16'h000F;
      txReady = 1'b0;
      send_frame(8'h13, 16'h00FF, 16'h0F0F);
      chk("log_en", {28'h0, shiftEn, cmpEn, logicEn, arithEn}, 32'h2);
      chk("log_func", {30'h0, aluFunc}, 32'h3);
      tick();
      tick();
      snap_err = err_cnt;
      send_byte(8'hC1);
      send_byte(8'h22);
      send_byte(8'h7E);
      chk("stray_tx", {22'h0, busy, txValid, txData}, 32'h30F);
      chk("stray_noerr", err_cnt - snap_err, 32'd0);
      txReady = 1'b1;
      tick();
      chk("stray_tx1", {23'h0, txValid, txData}, 32'h100);
      tick();
      chk("stray_done", {30'h0, txValid, busy}, 32'h0);
      aluResult = 16'h0002;
      send_frame(8'h20, 16'h0001, 16'h0002);
      chk("b2b_en", {28'h0, shiftEn, cmpEn, logicEn, arithEn}, 32'h4);
      chk("b2b_AB", {A, B}, 32'h0001_0002);
      chk("b2b_func", {30'h0, aluFunc}, 32'h0);
      repeat (4) tick();
      chk("b2b_done", {30'h0, txValid, busy}, 32'h0);
      chk("stray_bytes", acc_word(), 32'h0F00_0200);
      chk("stray_nbytes", acc_q.size(), 32'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
